// File: rtl/sc_pp_decoder.sv
// Progressive-precision stochastic-to-binary decoder: counts ones in a 2^TW bit
// stream and stops once the upper P bits of the saturated count are settled.
module sc_pp_decoder #(
  parameter int TW = 6,
  parameter int P  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          bit_in,
  output logic          busy,
  output logic          done,
  output logic [P-1:0]  Bz,
  output logic [TW:0]   ones,
  output logic [TW:0]   cycles,
  output logic          early
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [TW:0] L_C   = {1'b1, {TW{1'b0}}};
  localparam logic [TW:0] ONE_C = {{TW{1'b0}}, 1'b1};

  function automatic logic [TW-1:0] sat(input logic [TW:0] x);
    return (x >= L_C) ? {TW{1'b1}} : x[TW-1:0];
  endfunction

  function automatic logic [P-1:0] top(input logic [TW:0] x);
    logic [TW-1:0] s;
    s = sat(x);
    return s[TW-1:TW-P];
  endfunction

  state_t        state_q, state_d;
  logic [TW:0]   c_q, c_d, t_q, t_d;
  logic [P-1:0]  bz_q, bz_d;
  logic [TW:0]   ones_q, ones_d, cycles_q, cycles_d;
  logic          early_q, early_d;

  logic [TW:0]   c_nx, t_nx, rem, bound;
  logic          term;

  // c' + rem never exceeds L, so TW+1 bits hold the upper bound exactly.
  assign c_nx  = c_q + {{TW{1'b0}}, bit_in};
  assign t_nx  = t_q + ONE_C;
  assign rem   = L_C - t_nx;
  assign bound = c_nx + rem;
  assign term  = (top(c_nx) == top(bound)) || (t_nx == L_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      t_q      <= '0;
      bz_q     <= '0;
      ones_q   <= '0;
      cycles_q <= '0;
      early_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      t_q      <= t_d;
      bz_q     <= bz_d;
      ones_q   <= ones_d;
      cycles_q <= cycles_d;
      early_q  <= early_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    t_d      = t_q;
    bz_d     = bz_q;
    ones_d   = ones_q;
    cycles_d = cycles_q;
    early_d  = early_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          c_d     = '0;
          t_d     = '0;
          early_d = 1'b0;
        end
      end
      RUN: begin
        // A start while running wins over any bit presented in the same cycle.
        if (start) begin
          c_d = '0;
          t_d = '0;
        end else if (bit_valid) begin
          if (term) begin
            state_d  = DONE;
            bz_d     = top(c_nx);
            ones_d   = c_nx;
            cycles_d = t_nx;
            early_d  = (t_nx < L_C);
          end else begin
            c_d = c_nx;
            t_d = t_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign Bz     = bz_q;
  assign ones   = ones_q;
  assign cycles = cycles_q;
  assign early  = early_q;

endmodule

// File: tb/tb_sc_pp_decoder.sv
// Bench for sc_pp_decoder: directed stream patterns plus random streams checked
// against an arithmetic model of the early-termination rule.
module tb_sc_pp_decoder;
  localparam int TW = 6;
  localparam int P  = 2;
  localparam int L  = 1 << TW;

  logic          clk = 1'b0;
  logic          rst, start, bit_valid, bit_in;
  logic          busy, done, early;
  logic [P-1:0]  Bz;
  logic [TW:0]   ones, cycles;

  int n_tests = 0;
  int n_fail  = 0;
  bit stream [L];
  int e_ones, e_cyc, e_bz, e_early;
  int acc;

  sc_pp_decoder #(.TW(TW), .P(P)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .done(done), .Bz(Bz), .ones(ones), .cycles(cycles), .early(early)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int satv(input int x);
    return (x > L - 1) ? L - 1 : x;
  endfunction

  // Walks the stream bit by bit; stops at the first prefix whose lower and upper
  // possible final counts agree in their top P bits.
  function automatic void model();
    int c;
    bit fin;
    c = 0;
    fin = 0;
    for (int k = 1; k <= L && !fin; k++) begin
      c += int'(stream[k-1]);
      if ((satv(c) >> (TW - P)) == (satv(c + L - k) >> (TW - P)) || k == L) begin
        e_ones  = c;
        e_cyc   = k;
        e_bz    = satv(c) >> (TW - P);
        e_early = (k < L) ? 1 : 0;
        fin = 1;
      end
    end
  endfunction

  task automatic pulse_start(input bit with_bit);
    @(negedge clk);
    start = 1'b1; bit_valid = with_bit; bit_in = with_bit;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
  endtask

  task automatic run_stream(input bit stalls);
    acc = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (done) break;
      bit_valid = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_in = 1'($urandom_range(0, 1));
      if (bit_valid) begin
        bit_in = (acc < L) ? stream[acc] : 1'b1;
        acc++;
      end
    end
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic verify(input string tag, input int bz, input int o, input int cy, input int ea);
    check({tag, "_done"},   done, 1);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_Bz"},     Bz, bz);
    check({tag, "_ones"},   ones, o);
    check({tag, "_cycles"}, cycles, cy);
    check({tag, "_early"},  early, ea);
    check({tag, "_accepted"}, acc, cy);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_Bz", Bz, 0);
    check("rst_ones", ones, 0);
    check("rst_cycles", cycles, 0);
    check("rst_early", early, 0);

    // bits while idle must not start anything
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) @(negedge clk);
    bit_valid = 1'b0;
    check("idle_busy", busy, 0);

    for (int i = 0; i < L; i++) stream[i] = 1'b1;
    pulse_start(1'b0);
    run_stream(1'b0);
    verify("ones", 3, 48, 48, 1);

    for (int i = 0; i < L; i++) stream[i] = 1'b0;
    pulse_start(1'b0);
    run_stream(1'b0);
    verify("zeros", 0, 0, 49, 1);

    for (int i = 0; i < L; i++) stream[i] = ~i[0];
    pulse_start(1'b0);
    run_stream(1'b0);
    verify("alt", 2, 32, 63, 1);

    pulse_start(1'b0);
    run_stream(1'b1);
    verify("alt_stall", 2, 32, 63, 1);

    // restart from DONE keeps old results visible until the next termination
    pulse_start(1'b0);
    check("hold_Bz", Bz, 2);
    check("hold_ones", ones, 32);
    check("hold_cycles", cycles, 63);
    check("hold_early_clr", early, 0);

    // abort after 20 ones; the bit sent alongside the restart is dropped
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bit_valid = 1'b1; bit_in = 1'b1;
    end
    pulse_start(1'b1);
    for (int i = 0; i < L; i++) stream[i] = 1'b0;
    run_stream(1'b0);
    verify("abort", 0, 0, 49, 1);
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (10) @(negedge clk);
    bit_valid = 1'b0;
    check("done_ign_done", done, 1);
    check("done_ign_ones", ones, 0);
    check("done_ign_cycles", cycles, 49);
    check("done_ign_Bz", Bz, 0);

    for (int r = 0; r < 10; r++) begin
      int dens;
      bit stl;
      dens = int'($urandom_range(0, 100));
      stl  = 1'($urandom_range(0, 1));
      for (int i = 0; i < L; i++) stream[i] = (int'($urandom_range(0, 99)) < dens);
      model();
      pulse_start(1'b0);
      run_stream(stl);
      verify($sformatf("rand%0d", r), e_bz, e_ones, e_cyc, e_early);
    end

    // asynchronous reset between clock edges in the middle of a run
    for (int i = 0; i < L; i++) stream[i] = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bit_valid = 1'b1; bit_in = 1'b1;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_Bz", Bz, 0);
    check("arst_ones", ones, 0);
    check("arst_cycles", cycles, 0);
    check("arst_early", early, 0);
    bit_valid = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle", busy, 0);
    pulse_start(1'b0);
    run_stream(1'b0);
    verify("arst_ones_run", 3, 48, 48, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_pp_decoder.md
Name: sc_pp_decoder

Overview:
- Progressive-precision stochastic-to-binary decoder with early termination.
- Sits at the receiving end of a stochastic bitstream produced by the stream generator / application-circuit pair.
- Counts ones in an incoming bitstream of nominal length 2^TW.
- Stops as soon as the P most-significant bits of the final binary result can no longer change, then presents that result together with the consumed-bit count.

Parameters:
- TW, 6: log2 of nominal stream length; full count width.
- P, 2: output precision in MSBs; legal range 1..TW.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new conversion (clears counters).
- bit_valid  input  1  bit_in qualifier; a bit is accepted on any rising edge in RUN with bit_valid=1.
- bit_in  input  1  stochastic stream bit.
- busy  output  1  high in RUN.
- done  output  1  level; high in DONE until next start or reset.
- Bz  output  P  decoded result, upper P bits of the saturated count.
- ones  output  TW+1  ones counted at termination.
- cycles  output  TW+1  bits accepted at termination.
- early  output  1  1 if terminated before 2^TW bits were accepted.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, Bz, ones, cycles, early all 0; internal counters c and t = 0.
- Definitions:
  - L = 2^TW.
  - sat(x) = min(x, L-1).
  - top(x) = sat(x) >> (TW-P).
  - Final result Bz = top(final ones count); all-ones stream saturates to all-ones Bz.
- States:
  - IDLE: wait for start. bit_valid ignored.
  - RUN: on each accepted bit compute c' = c + bit_in, t' = t + 1, rem = L - t'. Terminate when top(c') == top(c' + rem) or t' == L. On terminate: next state DONE; latch Bz = top(c'), ones = c', cycles = t', early = (t' < L). Otherwise c<=c', t<=t'.
  - DONE: done=1, outputs held; bit_valid ignored; start -> RUN.
- Transitions:
  - IDLE --start--> RUN: c=0, t=0; done, early cleared.
  - DONE --start--> RUN: same clears; Bz/ones/cycles hold old values until the new termination.
  - RUN --start--> RUN: abort and restart; counters cleared; a bit_valid in the same cycle is discarded.
- Latency:
  - Termination decision is combinational on the accepted bit.
  - done/busy/outputs update on that same rising edge, so done is visible the cycle after the deciding bit was presented.
  - busy asserts the cycle after start.
- Widths: c, t are TW+1 bits; the bound sum c'+rem never exceeds L, so TW+1 bits suffice; compare after saturation.
- bit_valid gaps (stalls) in RUN: no state change; the result is independent of gap pattern.
- Reset mid-RUN: immediate return to IDLE with all outputs 0.
- P == TW: early termination occurs only via saturation or when lower and upper bounds coincide.

Test Plan (TW=6, P=2):
- All-ones stream, continuous valid -> done after 48 accepted bits; Bz=2'b11, ones=48, cycles=48, early=1.
- All-zeros stream -> done after 49 bits; Bz=2'b00, ones=0, cycles=49, early=1.
- Alternating 1,0,1,0... starting with 1 -> done after 63 bits; Bz=2'b10, ones=32, cycles=63, early=1.
- Alternating stream with bit_valid toggled randomly (50% stalls) -> identical Bz/ones/cycles to the continuous case; done position shifts with stalls only.
- Start pulsed mid-RUN after 20 ones, then all-zeros -> counters restart; done after 49 bits; Bz=00, ones=0. Bits sent while in DONE do not alter outputs.
- rst asserted asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately, state IDLE; a subsequent start plus all-ones stream reproduces the 48-bit result.
